// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift one
// odd-parity byte on device clocks, check the device ACK, report done/error.
// Optional build macro PS2_HOST_TX_RETRY_EN: on an error the byte is retried
// up to twice (three attempts) before tx_error is reported.
module ps2_host_tx #(
  parameter int unsigned CLK_HZ           = 100_000_000,
  parameter int unsigned INHIBIT_US       = 100,
  parameter int unsigned START_TIMEOUT_US = 15000,
  parameter int unsigned BIT_TIMEOUT_US   = 2000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int unsigned CYC_PER_US = CLK_HZ / 1_000_000;
  localparam int unsigned INH_CYC    = CYC_PER_US * INHIBIT_US;
  localparam int unsigned START_CYC  = CYC_PER_US * START_TIMEOUT_US;
  localparam int unsigned FRAME_CYC  = CYC_PER_US * BIT_TIMEOUT_US;
  localparam int unsigned MAX_A      = (INH_CYC > START_CYC) ? INH_CYC : START_CYC;
  localparam int unsigned MAX_CYC    = (MAX_A > FRAME_CYC) ? MAX_A : FRAME_CYC;
  localparam int          CNT_W      = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INH_CYC - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYC - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_WAIT_CLK, S_SHIFT,
    S_ACK, S_WAIT_IDLE, S_DONE, S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [9:0]       frame_q, frame_d;     // {stop, parity, d7..d0}
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [1:0]       clk_sync_q, data_sync_q;
  logic             clk_prev_q;
  logic             fall;
  logic             fail;
`ifdef PS2_HOST_TX_RETRY_EN
  logic [1:0]       retry_q, retry_d;
`endif

  // Two-flop synchronizers and previous clock level for falling-edge detect.
  // Reset to 1 so an idle bus never looks like a falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
      data_sync_q <= {data_sync_q[0], ps2_data_in};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  assign fall = clk_prev_q & ~clk_sync_q[1];

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  // Next-state logic; output registers are loaded alongside the state change
  // so each output is valid in the same cycle as the state that owns it.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q + CNT_W'(1);
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    fail      = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
    retry_d   = retry_q;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_start) begin
          frame_d  = {1'b1, ~^tx_data, tx_data};
          busy_d   = 1'b1;
          clk_oe_d = 1'b1;
          state_d  = S_INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
          retry_d  = '0;
`endif
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          data_oe_d = 1'b1;
          state_d   = S_RTS;
        end
      end
      S_RTS: begin
        // Releasing the clock with data held low is the start bit.
        clk_oe_d = 1'b0;
        cnt_d    = '0;
        state_d  = S_WAIT_CLK;
      end
      S_WAIT_CLK: begin
        if (fall) begin
          data_oe_d = ~frame_q[0];
          bit_cnt_d = 4'd1;
          cnt_d     = '0;
          state_d   = S_SHIFT;
        end else if (cnt_q == START_LAST) begin
          fail = 1'b1;
        end
      end
      S_SHIFT: begin
        if (cnt_q == FRAME_LAST) begin
          fail = 1'b1;
        end else if (fall) begin
          data_oe_d = ~frame_q[bit_cnt_q];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (cnt_q == FRAME_LAST) begin
          fail = 1'b1;
        end else if (fall) begin
          if (data_sync_q[1]) fail = 1'b1;
          else                state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (cnt_q == FRAME_LAST) begin
          fail = 1'b1;
        end else if (clk_sync_q[1] && data_sync_q[1]) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Common failure path: release the bus, then retry or report.
    if (fail) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      if (retry_q != 2'd2) begin
        retry_d  = retry_q + 2'd1;
        clk_oe_d = 1'b1;
        cnt_d    = '0;
        state_d  = S_INHIBIT;
      end else begin
        error_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_ERROR;
      end
`else
      error_d = 1'b1;
      busy_d  = 1'b0;
      state_d = S_ERROR;
`endif
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign tx_done     = done_q;
  assign tx_error    = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a bus-level device model. The DUT runs
// with CLK_HZ = 1 MHz so INHIBIT = 100 cycles, start timeout = 1500 cycles,
// frame timeout = 2000 cycles; the device clock half-period is 20 cycles.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH_CYC   = 100;
  localparam int START_CYC = 1500;
  localparam int HALF      = 20;
`ifdef PS2_HOST_TX_RETRY_EN
  localparam int ATTEMPTS  = 3;
`else
  localparam int ATTEMPTS  = 1;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0, n_err = 0, n_inh = 0, n_both = 0;
  logic clk_oe_prev = 1'b0;
  logic busy_at_pulse = 1'b0;

  always #5 clk = ~clk;

  // Open-drain bus with pull-ups.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_HZ(1_000_000), .INHIBIT_US(100),
    .START_TIMEOUT_US(1500), .BIT_TIMEOUT_US(2000)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tx_start(tx_start), .tx_data(tx_data),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .busy(busy), .tx_done(tx_done), .tx_error(tx_error)
  );

  // Pulse and inhibit-phase counters.
  always @(negedge clk) begin
    if (tx_done)  n_done++;
    if (tx_error) n_err++;
    if (tx_done && tx_error) n_both++;
    if (tx_done || tx_error) busy_at_pulse = busy;
    if (ps2_clk_oe && !clk_oe_prev) n_inh++;
    clk_oe_prev = ps2_clk_oe;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_start = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_release(output bit ok);
    int n;
    n = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 5000);
  endtask

  // Device side: sample start bit, then ten clocks sampling on rising edges,
  // then the 11th clock with optional ACK low.
  task automatic dev_frame(input bit ack, output logic [10:0] cap, output bit ok);
    bit rel;
    cap = '0;
    wait_release(rel);
    ok = rel;
    if (rel) begin
      repeat (5) @(negedge clk);
      cap[0] = ps2_data_in;
      for (int i = 1; i <= 10; i++) begin
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        cap[i] = ps2_data_in;
        repeat (HALF) @(negedge clk);
      end
      if (ack) dev_data_low = 1'b1;
      repeat (5) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (5) @(negedge clk);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_end(input int base);
    int n;
    n = 0;
    while ((n_done + n_err) == base && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("end_within_bound", 32'(n < 4000), 32'd1);
  endtask

  logic [7:0]  vec_d [3] = '{8'hFF, 8'h00, 8'h01};
  logic        vec_p [3] = '{1'b1, 1'b1, 1'b0};

  initial begin
    logic [10:0] cap;
    bit ok;
    int bd, be, bi, n;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_error", 32'(tx_error), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Nominal 0xED with inhibit / RTS timing.
    bd = n_done; be = n_err; bi = n_inh;
    send(8'hED);
    n = 0;
    while (ps2_clk_oe && !ps2_data_oe && n < 20000) begin
      n++;
      @(negedge clk);
    end
    chk("inhibit_cycles", 32'(n), 32'(INH_CYC));
    chk("rts_clk_oe", 32'(ps2_clk_oe), 32'd1);
    chk("rts_data_oe", 32'(ps2_data_oe), 32'd1);
    @(negedge clk);
    chk("release_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("release_data_oe", 32'(ps2_data_oe), 32'd1);
    dev_frame(1'b1, cap, ok);
    chk("ed_dev_ok", 32'(ok), 32'd1);
    chk("ed_frame", 32'(cap), 32'h7DA);
    wait_end(bd + be);
    repeat (20) @(negedge clk);
    chk("ed_done_count", 32'(n_done - bd), 32'd1);
    chk("ed_error_count", 32'(n_err - be), 32'd0);
    chk("ed_inhibit_count", 32'(n_inh - bi), 32'd1);
    chk("ed_busy_at_pulse", 32'(busy_at_pulse), 32'd0);
    chk("ed_busy_after", 32'(busy), 32'd0);

    // Parity corner bytes.
    for (int v = 0; v < 3; v++) begin
      bd = n_done; be = n_err;
      send(vec_d[v]);
      dev_frame(1'b1, cap, ok);
      chk("par_dev_ok", 32'(ok), 32'd1);
      chk("par_bit", 32'(cap[9]), 32'(vec_p[v]));
      chk("par_frame", 32'(cap), 32'({1'b1, vec_p[v], vec_d[v], 1'b0}));
      wait_end(bd + be);
      repeat (10) @(negedge clk);
      chk("par_done_count", 32'(n_done - bd), 32'd1);
    end

    // Missing ACK.
    bd = n_done; be = n_err; bi = n_inh;
    send(8'hA5);
    for (int a = 0; a < ATTEMPTS; a++) begin
      dev_frame(1'b0, cap, ok);
      chk("nack_dev_ok", 32'(ok), 32'd1);
    end
    wait_end(bd + be);
    repeat (20) @(negedge clk);
    chk("nack_error_count", 32'(n_err - be), 32'd1);
    chk("nack_done_count", 32'(n_done - bd), 32'd0);
    chk("nack_inhibit_count", 32'(n_inh - bi), 32'(ATTEMPTS));
    chk("nack_busy_at_pulse", 32'(busy_at_pulse), 32'd0);
    chk("nack_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("nack_data_oe", 32'(ps2_data_oe), 32'd0);

    // Start timeout: device never clocks.
    bd = n_done; be = n_err; bi = n_inh;
    send(8'h3C);
    for (int a = 0; a < ATTEMPTS; a++) begin
      wait_release(ok);
      chk("to_release_seen", 32'(ok), 32'd1);
      n = 0;
      while (!tx_error && !ps2_clk_oe && n < 3000) begin
        @(negedge clk);
        n++;
      end
      chk("to_cycles", 32'(n), 32'(START_CYC));
    end
    repeat (20) @(negedge clk);
    chk("to_error_count", 32'(n_err - be), 32'd1);
    chk("to_done_count", 32'(n_done - bd), 32'd0);
    chk("to_inhibit_count", 32'(n_inh - bi), 32'(ATTEMPTS));
    chk("to_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("to_data_oe", 32'(ps2_data_oe), 32'd0);

    // Busy rejection: 0x55 offered mid-frame must be ignored.
    bd = n_done; be = n_err; bi = n_inh;
    send(8'hED);
    fork
      dev_frame(1'b1, cap, ok);
      begin
        repeat (300) @(negedge clk);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'h00;
      end
    join
    chk("rej_dev_ok", 32'(ok), 32'd1);
    chk("rej_frame", 32'(cap), 32'h7DA);
    wait_end(bd + be);
    repeat (400) @(negedge clk);
    chk("rej_done_count", 32'(n_done - bd), 32'd1);
    chk("rej_inhibit_count", 32'(n_inh - bi), 32'd1);
    chk("rej_busy_after", 32'(busy), 32'd0);

    // Asynchronous reset mid-SHIFT while driving a zero bit.
    send(8'h00);
    wait_release(ok);
    chk("rst_mid_release", 32'(ok), 32'd1);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    chk("rst_mid_data_oe_before", 32'(ps2_data_oe), 32'd1);
    chk("rst_mid_busy_before", 32'(busy), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("rst_mid_data_oe", 32'(ps2_data_oe), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    bd = n_done; be = n_err;
    repeat (50) @(negedge clk);
    chk("rst_mid_no_done", 32'(n_done - bd), 32'd0);
    chk("rst_mid_no_error", 32'(n_err - be), 32'd0);

    chk("done_error_overlap", 32'(n_both), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
- The reverse direction of the existing ps2 receive path. It shares PS2Clk and PS2Data with that path through open-drain pad logic in top.
- Performs the inhibit / request-to-send sequence, shifts data on device-generated clocks, checks the device ACK and reports done or error.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- INHIBIT_US, 100, time ps2_clk is held low before request-to-send, in µs.
- START_TIMEOUT_US, 15000, maximum wait after clock release for the first device falling edge.
- BIT_TIMEOUT_US, 2000, maximum time for the whole frame from the first falling edge to the ACK.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset_n  input  1  asynchronous, active-low reset.
- tx_start  input  1  single-cycle request; sampled only when busy=0.
- tx_data  input  8  command byte, latched on an accepted tx_start.
- ps2_clk_in  input  1  raw PS2Clk pad level (asynchronous).
- ps2_data_in  input  1  raw PS2Data pad level (asynchronous).
- ps2_clk_oe  output  1  1 = pull PS2Clk low; 0 = release (high-Z).
- ps2_data_oe  output  1  1 = pull PS2Data low; 0 = release.
- busy  output  1  high from an accepted start until done or error.
- tx_done  output  1  one-cycle pulse: frame sent and ACK received.
- tx_error  output  1  one-cycle pulse: timeout or missing ACK.

Behaviour:
- Reset (async, reset_n=0):
  - state IDLE; ps2_clk_oe=0, ps2_data_oe=0, busy=0, tx_done=0, tx_error=0.
  - All counters cleared. Lines are released immediately, even mid-frame.
- Input conditioning:
  - ps2_clk_in and ps2_data_in each pass through a 2-FF synchronizer.
  - A falling edge (fall) is declared when the synchronized clk was 1 last cycle and is 0 this cycle.
  - Edge detection adds 3 cycles of latency, which is acceptable because the PS/2 half-period is ≥30 µs.
- Frame: shift register {stop=1, parity, d7..d0}. Parity is odd: parity = ~^tx_data.
- States:
  - IDLE: on tx_start, latch tx_data, busy<=1, go to INHIBIT the next cycle. tx_start while busy is ignored.
  - INHIBIT: ps2_clk_oe=1 for exactly CLK_HZ/1e6*INHIBIT_US cycles (10000 at defaults), then go to RTS.
  - RTS: one cycle with ps2_data_oe=1 and ps2_clk_oe=1. Next cycle ps2_clk_oe<=0 and the state goes to WAIT_CLK. data_oe stays 1; this is the start bit.
  - WAIT_CLK: on fall, drive d0 (data_oe = ~bit) and set bit_cnt=1, go to SHIFT.
    - No fall within START_TIMEOUT_US → ERROR.
  - SHIFT: on each fall, bit_cnt increments and the output updates:
    - bit_cnt 1..7 → d1..d7;
    - 8 → parity;
    - 9 → stop (data_oe=0), go to ACK.
    - Data changes only on fall, while the device holds clk low.
  - ACK: on the next fall (the 11th falling edge of the frame), sample the synchronized data.
    - 0 → WAIT_IDLE.
    - 1 → ERROR.
  - WAIT_IDLE: wait until synchronized clk=1 and data=1, then go to DONE.
  - DONE: tx_done=1 for one cycle, busy<=0, go to IDLE.
  - ERROR: release both lines, tx_error=1 for one cycle, busy<=0, go to IDLE.
  - Frame timeout: if BIT_TIMEOUT_US expires while in SHIFT, ACK or WAIT_IDLE → ERROR.
- Outputs are registered. tx_done and tx_error are never high in the same cycle.
- busy falls in the same cycle as the tx_done or tx_error pulse.
- A new tx_start is accepted from the cycle after busy falls.
- While busy, the external receiver sees the device clock. Top must ignore the receiver's rx_ready during busy; this block has no ports for that.

Optional Feature:
- Macro: PS2_HOST_TX_RETRY_EN.
- Defined:
  - On any error condition, the block releases both lines and re-enters INHIBIT with the same latched byte.
  - Up to 2 retries (3 attempts total). tx_error pulses only after the third attempt fails.
  - busy stays high throughout all attempts.
- Undefined: the first error goes straight to ERROR; no retry counter exists.

Test Plan:
- Reset: hold reset_n=0 mid-SHIFT → ps2_clk_oe=0 and ps2_data_oe=0 within 0 cycles (async); busy=0; no pulse on tx_done or tx_error after release.
- Nominal 0xED:
  - tx_start with tx_data=0xED → clk_oe high for 10000 cycles, then data_oe=1 with clk_oe=0.
  - The device model clocks at 12.5 kHz and samples on rising edges: start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Device ACK low → single tx_done, busy low.
- Parity 0xFF: device model captures parity bit = 1; 0x00 → parity bit = 1; 0x01 → parity bit = 0.
- Missing ACK: device leaves data high on the 11th clock → tx_error pulse; tx_done stays 0. With PS2_HOST_TX_RETRY_EN, exactly 3 INHIBIT phases occur before tx_error.
- Start timeout: device never clocks → tx_error 15 ms (1,500,000 cycles) after clock release; lines released.
- Busy rejection: tx_start with 0x55 during a 0xED frame → frame unaffected; only 0xED transmitted; one tx_done.
